// File: rtl/d0fifo_ctrl.sv
// FIFO controller for an external RAM with zero-latency reads. Pointers carry an
// extra wrap bit. Optional almost_full/almost_empty outputs: D0FIFO_CTRL_ALMOST_EN.
module d0fifo_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SIZE   = 32,
  parameter int AF_LVL = SIZE - 2,
  parameter int AE_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [WIDTH-1:0]       push_data,
  output logic                   pop_valid,
  input  logic                   pop_ready,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   ram_wen,
  output logic                   ram_ren,
  output logic [$clog2(SIZE)-1:0] ram_waddr,
  output logic [$clog2(SIZE)-1:0] ram_raddr,
  output logic [WIDTH-1:0]       ram_wdata,
  input  logic [WIDTH-1:0]       ram_rdata,
  output logic [$clog2(SIZE):0]  count,
  output logic                   full,
  output logic                   empty
`ifdef D0FIFO_CTRL_ALMOST_EN
  ,
  output logic                   almost_full,
  output logic                   almost_empty
`endif
);

  localparam int AW = $clog2(SIZE);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);

  assign empty      = w_empty;
  assign full       = w_full;
  assign count      = r_wp - r_rp;
  assign push_ready = !w_full && !flush;
  assign pop_valid  = !w_empty && !flush;

  // A push presented while reset is held must not reach the RAM.
  assign w_push = push_valid && push_ready && rst_n;
  assign w_pop  = pop_valid && pop_ready;

  assign ram_wen   = w_push;
  assign ram_waddr = r_wp[AW-1:0];
  assign ram_wdata = push_data;
  assign ram_ren   = pop_valid;
  assign ram_raddr = r_rp[AW-1:0];
  assign pop_data  = pop_valid ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
    end
  end

`ifdef D0FIFO_CTRL_ALMOST_EN
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LVL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LVL);

  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);
`endif

endmodule

// File: tb/tb_d0fifo_ctrl.sv
// Self-checking bench for d0fifo_ctrl (SIZE=4, WIDTH=16) with a zero-latency RAM
// model; checks every cycle against a queue-based reference model.
module tb_d0fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_data;
  logic        pop_valid;
  logic        pop_ready;
  logic [15:0] pop_data;
  logic        ram_wen;
  logic        ram_ren;
  logic [1:0]  ram_waddr;
  logic [1:0]  ram_raddr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef D0FIFO_CTRL_ALMOST_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  always #5 clk = ~clk;

  d0fifo_ctrl #(.WIDTH(16), .SIZE(4), .AF_LVL(3), .AE_LVL(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .count(count), .full(full), .empty(empty)
`ifdef D0FIFO_CTRL_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  // Zero-latency RAM: combinational read, write visible after the edge.
  logic [15:0] mem [4];
  always_ff @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  // Reference model: contents as a queue, plus running write/read counts.
  logic [15:0] q[$];
  int wr_idx = 0;
  int rd_idx = 0;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input logic pv, input logic [15:0] pd, input logic fl);
    int   n;
    logic e_full, e_empty, e_pr, e_pv, e_wen;
    n       = q.size();
    e_full  = (n == 4);
    e_empty = (n == 0);
    e_pr    = !e_full && !fl;
    e_pv    = !e_empty && !fl;
    e_wen   = pv && e_pr && rst_n;
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(e_empty));
    chk("full", 32'(full), 32'(e_full));
    chk("push_ready", 32'(push_ready), 32'(e_pr));
    chk("pop_valid", 32'(pop_valid), 32'(e_pv));
    chk("ram_ren", 32'(ram_ren), 32'(e_pv));
    chk("ram_raddr", 32'(ram_raddr), 32'(rd_idx % 4));
    chk("pop_data", 32'(pop_data), e_pv ? 32'(q[0]) : 32'd0);
    chk("ram_wen", 32'(ram_wen), 32'(e_wen));
    if (e_wen) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(wr_idx % 4));
      chk("ram_wdata", 32'(ram_wdata), 32'(pd));
    end
`ifdef D0FIFO_CTRL_ALMOST_EN
    chk("almost_full", 32'(almost_full), 32'(n >= 3));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
`endif
  endtask

  // One cycle: drive, check mid-cycle, clock, update the model.
  task automatic step(input logic pv, input logic [15:0] pd, input logic pr, input logic fl);
    int n;
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
    #2;
    check_now(pv, pd, fl);
    n = q.size();
    $display("[TB] t=%0t push=%0b data=%h pop=%0b flush=%0b count=%0d", $time, pv, pd, pr, fl, n);
    @(posedge clk);
    if (fl) begin
      q.delete(); wr_idx = 0; rd_idx = 0;
    end else begin
      if (pr && n > 0) begin
        void'(q.pop_front());
        rd_idx++;
      end
      if (pv && n < 4) begin
        q.push_back(pd);
        wr_idx++;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; push_valid = 1'b1; push_data = 16'hDEAD; pop_ready = 1'b1;
    #3;
    check_now(1'b1, 16'hDEAD, 1'b0);
    @(posedge clk);
    push_valid = 1'b0; pop_ready = 1'b0;
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push then pop
    step(1'b1, 16'h00A5, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Fill to full, refused push, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0005, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Wrap from address 0
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(16'h10 + i), 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end

    // Simultaneous push/pop at count 2, then at full
    step(1'b1, 16'h0B01, 1'b0, 1'b0);
    step(1'b1, 16'h0B02, 1'b0, 1'b0);
    step(1'b1, 16'h0B03, 1'b1, 1'b0);
    step(1'b1, 16'h0B04, 1'b1, 1'b0);
    step(1'b1, 16'h0B05, 1'b0, 1'b0);
    step(1'b1, 16'h0B06, 1'b0, 1'b0);
    step(1'b1, 16'h0B07, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Flush at count 3, then the next push lands at address 0
    step(1'b1, 16'h0C00, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h0077, 1'b0, 1'b0);
    step(1'b1, 16'h0078, 1'b0, 1'b0);

    // Asynchronous reset mid-stream with a push pending
    push_valid = 1'b1; push_data = 16'h0999; pop_ready = 1'b1; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete(); wr_idx = 0; rd_idx = 0;
    check_now(1'b1, 16'h0999, 1'b0);
    #2 push_valid = 1'b0; pop_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 16'h0AAA, 1'b0, 1'b0);

    // Occupancy sweep 0..4 for the threshold flags
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h0D00 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
